// File: rtl/hdd_pkg.sv
// Shared types and constants for the doorway beam direction detector.
// Beam pairs are always written {fa, fb}: outer beam in the MSB, inner beam in the LSB.
`timescale 1ns/1ps
package hdd_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

    typedef logic [1:0] beam_pair_t;

    localparam beam_pair_t PAIR_NONE   = 2'b00;
    localparam beam_pair_t PAIR_B_ONLY = 2'b01;
    localparam beam_pair_t PAIR_A_ONLY = 2'b10;
    localparam beam_pair_t PAIR_BOTH   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ENT1,
        ENT2,
        ENT3,
        EXT1,
        EXT2,
        EXT3,
        WAIT_CLEAR
    } dir_state_t;

    // States in which the dwell timer runs.
    function automatic logic is_tracking(input dir_state_t state);
        return (state != IDLE) && (state != WAIT_CLEAR);
    endfunction

    // Passage tracking on filtered beam levels; the exit path is the entry path with the beams swapped.
    function automatic dir_state_t dir_next(input dir_state_t state, input beam_pair_t pair);
        dir_state_t next_state;
        next_state = state;
        case (state)
            IDLE: begin
                case (pair)
                    PAIR_A_ONLY: next_state = ENT1;
                    PAIR_B_ONLY: next_state = EXT1;
                    PAIR_BOTH:   next_state = WAIT_CLEAR;
                    default:     next_state = IDLE;
                endcase
            end
            ENT1: begin
                case (pair)
                    PAIR_BOTH:   next_state = ENT2;
                    PAIR_NONE:   next_state = IDLE;
                    PAIR_B_ONLY: next_state = WAIT_CLEAR;
                    default:     next_state = ENT1;
                endcase
            end
            ENT2: begin
                case (pair)
                    PAIR_B_ONLY: next_state = ENT3;
                    PAIR_A_ONLY: next_state = ENT1;
                    PAIR_NONE:   next_state = WAIT_CLEAR;
                    default:     next_state = ENT2;
                endcase
            end
            ENT3: begin
                case (pair)
                    PAIR_NONE:   next_state = IDLE;
                    PAIR_BOTH:   next_state = ENT2;
                    PAIR_A_ONLY: next_state = WAIT_CLEAR;
                    default:     next_state = ENT3;
                endcase
            end
            EXT1: begin
                case (pair)
                    PAIR_BOTH:   next_state = EXT2;
                    PAIR_NONE:   next_state = IDLE;
                    PAIR_A_ONLY: next_state = WAIT_CLEAR;
                    default:     next_state = EXT1;
                endcase
            end
            EXT2: begin
                case (pair)
                    PAIR_A_ONLY: next_state = EXT3;
                    PAIR_B_ONLY: next_state = EXT1;
                    PAIR_NONE:   next_state = WAIT_CLEAR;
                    default:     next_state = EXT2;
                endcase
            end
            EXT3: begin
                case (pair)
                    PAIR_NONE:   next_state = IDLE;
                    PAIR_BOTH:   next_state = EXT2;
                    PAIR_B_ONLY: next_state = WAIT_CLEAR;
                    default:     next_state = EXT3;
                endcase
            end
            default: begin
                next_state = (pair == PAIR_NONE) ? IDLE : WAIT_CLEAR;
            end
        endcase
        return next_state;
    endfunction

endpackage

// File: rtl/beam_debouncer.sv
// Two-flop synchroniser followed by a stability counter for one raw beam input.
// The filtered level only follows the synchronised level after DEBOUNCE_CYCLES consecutive disagreeing samples.
`timescale 1ns/1ps
module beam_debouncer
    import hdd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignments let sync_q2 sample the old sync_q1, giving a true two-stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == filtered) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filtered <= sync_q2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/beam_direction_detector.sv
// Doorway front-end: debounces the outer/inner beams and tracks passage direction,
// pulsing human_detected on entries and human_exited on exits, with a fault level for stuck or ambiguous beams.
`timescale 1ns/1ps
module beam_direction_detector
    import hdd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic beam_a,
    input  logic beam_b,
    output logic human_detected,
    output logic human_exited,
    output logic fault,
    output logic busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          fa;
    logic          fb;
    dir_state_t    state;
    dir_state_t    next_state;
    logic [TW-1:0] timer;

    beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .raw      (beam_a),
        .filtered (fa)
    );

    beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .raw      (beam_b),
        .filtered (fb)
    );

    // NOTE: next_state is assigned before any condition so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = dir_next(state, {fa, fb});
        // A beam pattern that has not moved for the whole timeout is treated as stuck.
        if ((next_state == state) && is_tracking(state) && (timer == TIMER_LAST)) begin
            next_state = WAIT_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            timer          <= '0;
            human_detected <= 1'b0;
            human_exited   <= 1'b0;
            fault          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state != state) || !is_tracking(state)) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            human_detected <= (state == ENT3) && (next_state == IDLE);
            human_exited   <= (state == EXT3) && (next_state == IDLE);
            fault          <= (next_state == WAIT_CLEAR);
            busy           <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_beam_direction_detector.sv
// Bench for beam_direction_detector: directed vector table, timeout/reset/stream sequences,
// then random beam activity compared cycle by cycle against a window-and-table reference model.
`timescale 1ns/1ps
module tb_beam_direction_detector;

    localparam int DEB = 4;
    localparam int TMO = 50;
    localparam int LAT = 2 + DEB + 1;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic beam_a = 1'b0;
    logic beam_b = 1'b0;
    logic human_detected;
    logic human_exited;
    logic fault;
    logic busy;

    beam_direction_detector #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .beam_a         (beam_a),
        .beam_b         (beam_b),
        .human_detected (human_detected),
        .human_exited   (human_exited),
        .fault          (fault),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and remembers when the last one and the last busy fall happened.
    int   det_cnt        = 0;
    int   ex_cnt         = 0;
    int   last_pulse_cyc = -1;
    int   busy_fall_cyc  = -1;
    bit   both_seen      = 1'b0;
    logic prev_busy      = 1'b0;
    always @(negedge clk) begin
        if (human_detected) begin
            det_cnt        <= det_cnt + 1;
            last_pulse_cyc <= cyc;
        end
        if (human_exited) begin
            ex_cnt         <= ex_cnt + 1;
            last_pulse_cyc <= cyc;
        end
        if (human_detected && human_exited) both_seen <= 1'b1;
        if (prev_busy && !busy) busy_fall_cyc <= cyc;
        prev_busy <= busy;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit    a;
        bit    b;
        int    hold;
        bit    exp_busy;
        bit    exp_fault;
        int    exp_det;
        int    exp_ex;
        int    lat;      // 1: check entry latency, 2: check exit latency
        string tag;
    } vec_t;

    function automatic vec_t mk(bit a, bit b, int hold, bit eb, bit ef, int ed, int ee, int lat, string tag);
        vec_t v;
        v.a = a; v.b = b; v.hold = hold;
        v.exp_busy = eb; v.exp_fault = ef; v.exp_det = ed; v.exp_ex = ee;
        v.lat = lat; v.tag = tag;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // State ids: 0 IDLE, 1-3 entry steps, 4-6 exit steps, 7 waiting for both beams clear.
    // Column = 2*fa + fb.
    int tbl [8][4] = '{
        '{0, 4, 1, 7},
        '{0, 7, 1, 2},
        '{7, 3, 1, 2},
        '{0, 3, 7, 2},
        '{0, 4, 7, 5},
        '{7, 4, 6, 5},
        '{0, 7, 6, 5},
        '{0, 7, 7, 7}
    };

    int         m_state;
    int         m_dwell;
    bit         m_fa;
    bit         m_fb;
    logic [3:0] m_out;
    bit         ha[$];
    bit         hb[$];
    bit         wa[$];
    bit         wb[$];

    function automatic bit all_differ(input bit q[$], input bit f);
        if (q.size() < DEB) return 1'b0;
        foreach (q[i]) if (q[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_dwell = 0;
        m_fa    = 1'b0;
        m_fb    = 1'b0;
        m_out   = 4'b0000;
        ha = '{1'b0, 1'b0};
        hb = '{1'b0, 1'b0};
        wa = {};
        wb = {};
    endtask

    // One clock edge: FSM on old filtered levels, then filters on the two-edge-old raw samples.
    task automatic model_step(input bit a, input bit b);
        int p;
        int nxt;
        bit sa;
        bit sb;
        sa  = ha[0];
        sb  = hb[0];
        p   = (m_fa ? 2 : 0) + (m_fb ? 1 : 0);
        nxt = tbl[m_state][p];
        if (nxt == m_state && m_state >= 1 && m_state <= 6) begin
            m_dwell++;
            if (m_dwell == TMO) nxt = 7;
        end
        if (nxt != m_state) m_dwell = 0;
        m_out   = {(m_state == 3 && nxt == 0), (m_state == 6 && nxt == 0), (nxt == 7), (nxt != 0)};
        m_state = nxt;
        wa.push_back(sa);
        if (wa.size() > DEB) void'(wa.pop_front());
        wb.push_back(sb);
        if (wb.size() > DEB) void'(wb.pop_front());
        if (all_differ(wa, m_fa)) m_fa = !m_fa;
        if (all_differ(wb, m_fb)) m_fb = !m_fb;
        ha.push_back(a);
        void'(ha.pop_front());
        hb.push_back(b);
        void'(hb.pop_front());
    endtask

    task automatic hold_beams(input bit a, input bit b, input int n);
        beam_a = a;
        beam_b = b;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[$];
        int   mark;
        int   det0;
        int   ex0;
        int   t_busy;
        int   t_fault;
        int   hold_left;

        vecs.push_back(mk(1, 0, 10, 1, 0, 0, 0, 0, "entry/a"));
        vecs.push_back(mk(1, 1, 10, 1, 0, 0, 0, 0, "entry/ab"));
        vecs.push_back(mk(0, 1, 10, 1, 0, 0, 0, 0, "entry/b"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 0, 1, "entry/clear"));
        vecs.push_back(mk(0, 1, 10, 1, 0, 1, 0, 0, "exit/b"));
        vecs.push_back(mk(1, 1, 10, 1, 0, 1, 0, 0, "exit/ab"));
        vecs.push_back(mk(1, 0, 10, 1, 0, 1, 0, 0, "exit/a"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 1, 2, "exit/clear"));
        vecs.push_back(mk(1, 0,  3, 0, 0, 1, 1, 0, "glitch/a3"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 1, 0, "glitch/after"));
        vecs.push_back(mk(1, 0, 10, 1, 0, 1, 1, 0, "retreat/a"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 1, 0, "retreat/clear"));
        vecs.push_back(mk(1, 1, 10, 1, 1, 1, 1, 0, "ambig/ab"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 1, 0, "ambig/clear"));
        vecs.push_back(mk(1, 0, 10, 1, 0, 1, 1, 0, "swap/a"));
        vecs.push_back(mk(0, 1, 10, 1, 1, 1, 1, 0, "swap/b"));
        vecs.push_back(mk(0, 0, 10, 0, 0, 1, 1, 0, "swap/clear"));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset/busy_low", busy, 0);
        check("reset/fault_low", fault, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("reset/busy", busy, 0);
        check("reset/fault", fault, 0);
        check("reset/det", human_detected, 0);
        check("reset/ex", human_exited, 0);

        // Directed table
        foreach (vecs[i]) begin
            mark   = cyc;
            beam_a = vecs[i].a;
            beam_b = vecs[i].b;
            repeat (vecs[i].hold) @(negedge clk);
            #1;
            check({vecs[i].tag, "/busy"}, busy, vecs[i].exp_busy);
            check({vecs[i].tag, "/fault"}, fault, vecs[i].exp_fault);
            check({vecs[i].tag, "/det_count"}, det_cnt, vecs[i].exp_det);
            check({vecs[i].tag, "/ex_count"}, ex_cnt, vecs[i].exp_ex);
            if (vecs[i].lat != 0) begin
                check({vecs[i].tag, "/latency"}, last_pulse_cyc - mark, LAT);
                check({vecs[i].tag, "/busy_drop"}, busy_fall_cyc, last_pulse_cyc);
            end
        end

        // Timeout: outer beam stuck
        det0    = det_cnt;
        ex0     = ex_cnt;
        t_busy  = -1;
        t_fault = -1;
        beam_a  = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            #1;
            if (busy && t_busy < 0) t_busy = cyc;
            if (fault && t_fault < 0) t_fault = cyc;
            if (i == 79) begin
                check("timeout/fault_held", fault, 1);
                beam_a = 1'b0;
            end
            if (i == 85) check("timeout/fault_until_filtered", fault, 1);
            if (i == 86) check("timeout/fault_drop", fault, 0);
        end
        check("timeout/delay", t_fault - t_busy, TMO);
        check("timeout/busy_end", busy, 0);
        check("timeout/no_det", det_cnt, det0);
        check("timeout/no_ex", ex_cnt, ex0);

        // Reset in the middle of an entry
        hold_beams(1, 0, 10);
        hold_beams(1, 1, 10);
        #1;
        check("midreset/in_ent2", busy, 1);
        reset = 1'b0;
        #1;
        check("midreset/outputs", {human_detected, human_exited, fault, busy}, 0);
        beam_a = 1'b0;
        beam_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("midreset/no_pulse", det_cnt, det0);
        check("midreset/idle", busy, 0);

        // Back-to-back entries
        det0 = det_cnt;
        ex0  = ex_cnt;
        for (int k = 0; k < 81; k++) begin
            hold_beams(1, 0, 10);
            hold_beams(1, 1, 10);
            hold_beams(0, 1, 10);
            hold_beams(0, 0, 10);
        end
        repeat (5) @(negedge clk);
        #1;
        check("stream/det_count", det_cnt - det0, 81);
        check("stream/ex_count", ex_cnt, ex0);

        // Random activity against the reference model
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_left == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 1) beam_a = !beam_a;
                    else                           beam_b = !beam_b;
                end else begin
                    beam_a = 1'($urandom_range(0, 1));
                    beam_b = 1'($urandom_range(0, 1));
                end
                hold_left = ($urandom_range(0, 15) == 0) ? 60 : int'($urandom_range(1, 12));
            end
            hold_left--;
            @(posedge clk);
            model_step(beam_a, beam_b);
            @(negedge clk);
            check("random/outputs", {human_detected, human_exited, fault, busy}, m_out);
        end

        check("never_both_pulses", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
